// File: rtl/pwm_ramp_sequencer_pkg.sv
// Shared definitions for the PWM ramp sequencer: state encodings and defaults.
package pwm_ramp_sequencer_pkg;

  // Default clk cycles per duty step: 50 ms at 100 MHz. Must be at least 2.
  localparam int unsigned STEP_DIV_DEF = 5_000_000;
  localparam int unsigned DUTY_W_DEF   = 4;
  localparam int unsigned FREQ_W_DEF   = 3;

  typedef enum logic [2:0] {
    TRACK   = 3'd0,
    RAMP    = 3'd1,
    RAMP_DN = 3'd2,
    SWITCH  = 3'd3,
    SETTLE  = 3'd4
  } state_t;

endpackage

// File: rtl/pwm_step_tick.sv
// Step tick generator: counts 0..STEP_DIV-1 while running and pulses tick_o
// on the cycle the count wraps. A clear restarts the count from 0, so the
// first tick after a clear arrives STEP_DIV cycles later.
module pwm_step_tick
  import pwm_ramp_sequencer_pkg::*;
#(
  parameter int unsigned STEP_DIV = STEP_DIV_DEF
) (
  input  logic clk_i,
  input  logic reset,
  input  logic clr_i,
  input  logic run_i,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(STEP_DIV);
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running step counter, held at 0 when idle or cleared.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr_i || !run_i) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick_o = run_i && (cnt == LAST);

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// PWM ramp sequencer: soft-starts the applied duty one LSB per step tick and
// sequences frequency changes as ramp-down, switch, settle, ramp-up so the
// motor never sees an abrupt duty or frequency jump.
//
// state   | meaning
// --------+-----------------------------------------------------------
// TRACK   | duty_o matches target, frequency stable, idle
// RAMP    | stepping duty_o toward the live effective target
// RAMP_DN | stepping duty_o to 0 ahead of a frequency change
// SWITCH  | single cycle: load pending frequency, pulse freq_upd_o
// SETTLE  | duty held at 0 for one step period after the switch
module pwm_ramp_sequencer
  import pwm_ramp_sequencer_pkg::*;
#(
  parameter int unsigned STEP_DIV = STEP_DIV_DEF,
  parameter int unsigned DUTY_W   = DUTY_W_DEF,
  parameter int unsigned FREQ_W   = FREQ_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic              en_i,
  input  logic [DUTY_W-1:0] tgt_duty_i,
  input  logic [FREQ_W-1:0] tgt_freq_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic [FREQ_W-1:0] freq_o,
  output logic              freq_upd_o,
  output logic              busy_o
);

  state_t            state, state_nxt;
  logic [DUTY_W-1:0] duty_nxt;
  logic [FREQ_W-1:0] freq_nxt;
  logic [FREQ_W-1:0] pend_freq, pend_nxt;
  logic              upd_nxt;
  logic [DUTY_W-1:0] eff_tgt;
  logic              tick;
  logic              run;
  logic              clr;

  assign eff_tgt = en_i ? tgt_duty_i : '0;
  assign run     = (state == RAMP) || (state == RAMP_DN) || (state == SETTLE);
  // Restart the step period on every state change.
  assign clr     = (state_nxt != state);
  assign busy_o  = (state != TRACK);

  pwm_step_tick #(
    .STEP_DIV(STEP_DIV)
  ) u_step_tick (
    .clk_i (clk_i),
    .reset (reset),
    .clr_i (clr),
    .run_i (run),
    .tick_o(tick)
  );

  // State register.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      state <= TRACK;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath update decisions.
  always_comb begin
    state_nxt = state;
    duty_nxt  = duty_o;
    freq_nxt  = freq_o;
    pend_nxt  = pend_freq;
    upd_nxt   = 1'b0;
    case (state)
      TRACK: begin
        if (tgt_freq_i != freq_o) begin
          pend_nxt  = tgt_freq_i;
          state_nxt = RAMP_DN;
        end else if (eff_tgt != duty_o) begin
          state_nxt = RAMP;
        end
      end
      RAMP: begin
        if (tgt_freq_i != freq_o) begin
          pend_nxt  = tgt_freq_i;
          state_nxt = RAMP_DN;
        end else if (eff_tgt == duty_o) begin
          state_nxt = TRACK;
        end else if (tick) begin
          // Target is sampled live; +/-1 steps can never overshoot or wrap.
          duty_nxt = (eff_tgt > duty_o) ? duty_o + DUTY_W'(1) : duty_o - DUTY_W'(1);
        end
      end
      RAMP_DN: begin
        // Latest frequency request wins; only one switch per sequence.
        pend_nxt = tgt_freq_i;
        if (duty_o == '0) begin
          state_nxt = SWITCH;
        end else if (tick) begin
          duty_nxt = duty_o - DUTY_W'(1);
        end
      end
      SWITCH: begin
        freq_nxt  = pend_freq;
        upd_nxt   = 1'b1;
        state_nxt = SETTLE;
      end
      SETTLE: begin
        duty_nxt = '0;
        if (tgt_freq_i != freq_o) begin
          // Duty is already 0, so go straight back to switching.
          pend_nxt  = tgt_freq_i;
          state_nxt = SWITCH;
        end else if (tick) begin
          state_nxt = (eff_tgt == '0) ? TRACK : RAMP;
        end
      end
      default: begin
        state_nxt = TRACK;
      end
    endcase
  end

  // Applied duty, frequency, pending request and update pulse registers.
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      duty_o     <= '0;
      freq_o     <= '0;
      pend_freq  <= '0;
      freq_upd_o <= 1'b0;
    end else begin
      duty_o     <= duty_nxt;
      freq_o     <= freq_nxt;
      pend_freq  <= pend_nxt;
      freq_upd_o <= upd_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer with a 4-cycle step period.
module tb_pwm_ramp_sequencer;

  logic       clk_i = 1'b0;
  logic       reset;
  logic       en_i;
  logic [3:0] tgt_duty_i;
  logic [2:0] tgt_freq_i;
  logic [3:0] duty_o;
  logic [2:0] freq_o;
  logic       freq_upd_o;
  logic       busy_o;

  int passed = 0;
  int total  = 0;
  int pulses = 0;

  typedef struct {
    logic       en;
    logic [3:0] duty;
    logic [2:0] freq;
    int         cyc;
    logic [3:0] e_duty;
    logic [2:0] e_freq;
    logic       e_busy;
    logic       e_upd;
  } vec_t;

  vec_t vecs[$];

  pwm_ramp_sequencer #(
    .STEP_DIV(4),
    .DUTY_W  (4),
    .FREQ_W  (3)
  ) dut (
    .clk_i     (clk_i),
    .reset     (reset),
    .en_i      (en_i),
    .tgt_duty_i(tgt_duty_i),
    .tgt_freq_i(tgt_freq_i),
    .duty_o    (duty_o),
    .freq_o    (freq_o),
    .freq_upd_o(freq_upd_o),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Count frequency-update pulses.
  always @(negedge clk_i) begin
    if (freq_upd_o) pulses++;
  end

  function automatic void add(input logic en, input int d, input int f, input int cyc,
                              input int ed, input int ef, input logic eb, input logic eu);
    vec_t v;
    v.en = en; v.duty = 4'(d); v.freq = 3'(f); v.cyc = cyc;
    v.e_duty = 4'(ed); v.e_freq = 3'(ef); v.e_busy = eb; v.e_upd = eu;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) $display("FAIL %s (step %0d): got %0d, expected %0d", name, idx, act, exp);
    else passed++;
  endtask

  task automatic check_all(input string tag, input int idx, input int ed, input int ef,
                           input int eb, input int eu);
    check({tag, ".duty"}, idx, int'(duty_o), ed);
    check({tag, ".freq"}, idx, int'(freq_o), ef);
    check({tag, ".busy"}, idx, int'(busy_o), eb);
    check({tag, ".upd"}, idx, int'(freq_upd_o), eu);
  endtask

  initial begin
    int p0;
    // 1: ramp up 0 -> 5
    add(1,5,0,1, 0,0,1,0); add(1,5,0,4, 1,0,1,0); add(1,5,0,4, 2,0,1,0);
    add(1,5,0,4, 3,0,1,0); add(1,5,0,4, 4,0,1,0); add(1,5,0,4, 5,0,1,0);
    add(1,5,0,1, 5,0,0,0);
    // 2: ramp down 5 -> 2
    add(1,2,0,1, 5,0,1,0); add(1,2,0,4, 4,0,1,0); add(1,2,0,4, 3,0,1,0);
    add(1,2,0,4, 2,0,1,0); add(1,2,0,1, 2,0,0,0);
    // back to 5
    add(1,5,0,1, 2,0,1,0); add(1,5,0,4, 3,0,1,0); add(1,5,0,4, 4,0,1,0);
    add(1,5,0,4, 5,0,1,0); add(1,5,0,1, 5,0,0,0);
    // 3: frequency 0 -> 6
    add(1,5,6,1, 5,0,1,0); add(1,5,6,4, 4,0,1,0); add(1,5,6,4, 3,0,1,0);
    add(1,5,6,4, 2,0,1,0); add(1,5,6,4, 1,0,1,0); add(1,5,6,4, 0,0,1,0);
    add(1,5,6,1, 0,0,1,0); add(1,5,6,1, 0,6,1,1); add(1,5,6,1, 0,6,1,0);
    add(1,5,6,3, 0,6,1,0); add(1,5,6,4, 1,6,1,0); add(1,5,6,4, 2,6,1,0);
    add(1,5,6,4, 3,6,1,0); add(1,5,6,4, 4,6,1,0); add(1,5,6,4, 5,6,1,0);
    add(1,5,6,1, 5,6,0,0);
    // 4: request 3, then 2 during ramp-down
    add(1,5,3,1, 5,6,1,0); add(1,5,3,4, 4,6,1,0);
    add(1,5,2,4, 3,6,1,0); add(1,5,2,4, 2,6,1,0); add(1,5,2,4, 1,6,1,0);
    add(1,5,2,4, 0,6,1,0); add(1,5,2,1, 0,6,1,0); add(1,5,2,1, 0,2,1,1);
    add(1,5,2,1, 0,2,1,0); add(1,5,2,3, 0,2,1,0); add(1,5,2,4, 1,2,1,0);
    add(1,5,2,4, 2,2,1,0); add(1,5,2,4, 3,2,1,0); add(1,5,2,4, 4,2,1,0);
    add(1,5,2,4, 5,2,1,0); add(1,5,2,1, 5,2,0,0);
    // 5: disable ramps to 0; ramp up, drop en at 3, re-enable
    add(0,5,2,1, 5,2,1,0); add(0,5,2,4, 4,2,1,0); add(0,5,2,4, 3,2,1,0);
    add(0,5,2,4, 2,2,1,0); add(0,5,2,4, 1,2,1,0); add(0,5,2,4, 0,2,1,0);
    add(0,5,2,1, 0,2,0,0);
    add(1,9,2,1, 0,2,1,0); add(1,9,2,4, 1,2,1,0); add(1,9,2,4, 2,2,1,0);
    add(1,9,2,4, 3,2,1,0);
    add(0,9,2,4, 2,2,1,0); add(0,9,2,4, 1,2,1,0); add(0,9,2,4, 0,2,1,0);
    add(0,9,2,1, 0,2,0,0); add(0,9,2,10, 0,2,0,0);
    add(1,9,2,1, 0,2,1,0); add(1,9,2,4, 1,2,1,0); add(1,9,2,8, 3,2,1,0);
    add(1,9,2,12, 6,2,1,0); add(1,9,2,12, 9,2,1,0); add(1,9,2,1, 9,2,0,0);
    // full-scale top: 9 -> 15, then hold (no wrap)
    add(1,15,2,1, 9,2,1,0); add(1,15,2,12, 12,2,1,0); add(1,15,2,12, 15,2,1,0);
    add(1,15,2,1, 15,2,0,0); add(1,15,2,8, 15,2,0,0);
    // ramp-down toward freq 5 until duty 3
    add(1,15,5,1, 15,2,1,0); add(1,15,5,4, 14,2,1,0); add(1,15,5,20, 9,2,1,0);
    add(1,15,5,24, 3,2,1,0);

    reset = 1'b0; en_i = 1'b0; tgt_duty_i = '0; tgt_freq_i = '0;
    #2;
    check_all("reset", 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_i);
    #1;
    reset = 1'b1;

    foreach (vecs[i]) begin
      en_i = vecs[i].en; tgt_duty_i = vecs[i].duty; tgt_freq_i = vecs[i].freq;
      repeat (vecs[i].cyc) @(posedge clk_i);
      #1;
      check_all("vec", i, int'(vecs[i].e_duty), int'(vecs[i].e_freq),
                int'(vecs[i].e_busy), int'(vecs[i].e_upd));
    end
    check("pulse_count", 0, pulses, 2);

    // 6: async reset in the middle of RAMP_DN at duty 3
    p0 = pulses;
    reset = 1'b0;
    en_i = 1'b1; tgt_duty_i = 4'd3; tgt_freq_i = 3'd0;
    #2;
    check_all("async_rst", 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk_i);
    #1;
    check_all("rst_hold", 0, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk_i); #1;
    check_all("resume", 0, 0, 0, 1, 0);
    repeat (4) @(posedge clk_i); #1;
    check_all("resume", 1, 1, 0, 1, 0);
    repeat (8) @(posedge clk_i); #1;
    check_all("resume", 2, 3, 0, 1, 0);
    @(posedge clk_i); #1;
    check_all("resume", 3, 3, 0, 0, 0);
    check("pulse_after_rst", 0, pulses - p0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
